// File: rtl/mem_stage.sv
// RV32I memory stage: one outstanding data-memory access, alignment checks,
// byte-lane steering, load extraction and a bounded bus wait.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_rd2,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic [1:0]  in_result_src,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_pc_cur,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [1:0]  wb_result_src,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_cur,
  output logic [1:0]  wb_fault
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        accept, is_mem, bad;
  logic        done, tmo, cnt_hit;
  logic        emit, emit_regw;
  logic [1:0]  emit_fault;
  logic [31:0] emit_rdata;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;

  logic        pend;
  logic [1:0]  pfault;
  logic        c_reg_write;
  logic        c_mem_read;
  logic [1:0]  c_result_src;
  logic [4:0]  c_rd;
  logic [2:0]  c_funct3;
  logic [31:0] c_alu;
  logic [31:0] c_pc;

  assign stall   = (state == WAIT);
  assign accept  = (state == IDLE) && in_valid;
  assign is_mem  = in_mem_read | in_mem_write;
  assign cnt_hit = (cnt == 8'(TIMEOUT_CYCLES - 1));
  assign done    = (state == WAIT) && mem_ready;
  assign tmo     = (state == WAIT) && !mem_ready && cnt_hit;

  always_comb begin
    bad = 1'b0;
    if (in_mem_read && in_mem_write)
      bad = 1'b1;
    else if (in_mem_read)
      bad = (in_funct3 == 3'd3) || (in_funct3[2:1] == 2'b11);
    else if (in_mem_write)
      bad = in_funct3[2] || (in_funct3[1:0] == 2'b11);
    if (is_mem && in_funct3[1:0] == 2'b01 && in_alu_result[0])
      bad = 1'b1;
    if (is_mem && in_funct3[1:0] == 2'b10 && in_alu_result[1:0] != 2'b00)
      bad = 1'b1;
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = 32'h0;
    if (in_mem_write) begin
      unique case (in_funct3[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << in_alu_result[1:0];
          wdata_nxt = {4{in_rd2[7:0]}};
        end
        2'b01: begin
          be_nxt    = 4'b0011 << {in_alu_result[1], 1'b0};
          wdata_nxt = {2{in_rd2[15:0]}};
        end
        default: wdata_nxt = in_rd2;
      endcase
    end
  end

  always_comb begin
    unique case (c_alu[1:0])
      2'b00:   ld_b = mem_rdata[7:0];
      2'b01:   ld_b = mem_rdata[15:8];
      2'b10:   ld_b = mem_rdata[23:16];
      default: ld_b = mem_rdata[31:24];
    endcase
    ld_h = c_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (c_funct3)
      3'd0:    ld_val = {{24{ld_b[7]}}, ld_b};
      3'd1:    ld_val = {{16{ld_h[15]}}, ld_h};
      3'd4:    ld_val = {24'h0, ld_b};
      3'd5:    ld_val = {16'h0, ld_h};
      default: ld_val = mem_rdata;
    endcase
  end

  // Completion beats timeout: tmo already excludes mem_ready.
  always_comb begin
    emit       = pend | done | tmo;
    emit_fault = pend ? pfault : (tmo ? 2'd2 : 2'd0);
    emit_regw  = c_reg_write && (emit_fault == 2'd0);
    emit_rdata = (done && c_mem_read) ? ld_val : 32'h0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && is_mem && !bad) state_nxt = WAIT;
      WAIT: if (done || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 8'h0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wdata     <= 32'h0;
      mem_be        <= 4'h0;
      pend          <= 1'b0;
      pfault        <= 2'd0;
      c_reg_write   <= 1'b0;
      c_mem_read    <= 1'b0;
      c_result_src  <= 2'd0;
      c_rd          <= 5'd0;
      c_funct3      <= 3'd0;
      c_alu         <= 32'h0;
      c_pc          <= 32'h0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_result_src <= 2'd0;
      wb_rd         <= 5'd0;
      wb_alu_result <= 32'h0;
      wb_read_data  <= 32'h0;
      wb_pc_cur     <= 32'h0;
      wb_fault      <= 2'd0;
    end else begin
      wb_valid <= emit;
      pend     <= 1'b0;
      if (emit) begin
        wb_reg_write  <= emit_regw;
        wb_result_src <= c_result_src;
        wb_rd         <= c_rd;
        wb_alu_result <= c_alu;
        wb_read_data  <= emit_rdata;
        wb_pc_cur     <= c_pc;
        wb_fault      <= emit_fault;
      end
      if (accept) begin
        c_reg_write  <= in_reg_write;
        c_mem_read   <= in_mem_read;
        c_result_src <= in_result_src;
        c_rd         <= in_rd;
        c_funct3     <= in_funct3;
        c_alu        <= in_alu_result;
        c_pc         <= in_pc_cur;
        pend         <= !is_mem || bad;
        pfault       <= bad ? 2'd1 : 2'd0;
        if (is_mem && !bad) begin
          cnt       <= 8'h0;
          mem_req   <= 1'b1;
          mem_we    <= in_mem_write;
          mem_addr  <= {in_alu_result[31:2], 2'b00};
          mem_wdata <= wdata_nxt;
          mem_be    <= be_nxt;
        end
      end
      if (done || tmo) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'h1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: loads, stores, faults, timeout,
// reset during an access and back-to-back ALU bundles.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_alu_result, in_rd2, in_pc_cur;
  logic [2:0]  in_funct3;
  logic        in_mem_read, in_mem_write, in_reg_write;
  logic [1:0]  in_result_src;
  logic [4:0]  in_rd;
  logic        stall, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_reg_write;
  logic [1:0]  wb_result_src, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_cur;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        regw;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_rd2(in_rd2),
    .in_funct3(in_funct3), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
    .in_result_src(in_result_src), .in_rd(in_rd),
    .in_pc_cur(in_pc_cur), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_result_src(wb_result_src), .wb_rd(wb_rd),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc_cur(wb_pc_cur), .wb_fault(wb_fault)
  );

  task automatic drive(input logic rd_, input logic wr_,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd,
                       input logic rw, input logic [31:0] pc);
    in_valid      = 1'b1;
    in_mem_read   = rd_;
    in_mem_write  = wr_;
    in_funct3     = f3;
    in_alu_result = a;
    in_rd2        = d;
    in_rd         = rd;
    in_reg_write  = rw;
    in_result_src = rd_ ? 2'd1 : 2'd0;
    in_pc_cur     = pc;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] rdv,
                      input logic [31:0] pc, input logic [4:0] rd,
                      input logic rw, input logic [1:0] f);
    exp_t x;
    x.alu = a; x.rdata = rdv; x.pc = pc; x.rd = rd;
    x.regw = rw; x.fault = f;
    sb.push_back(x);
  endtask

  task automatic issue(input logic rd_, input logic wr_,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd,
                       input logic rw, input logic [31:0] pc);
    drive(rd_, wr_, f3, a, d, rd, rw, pc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drives mem_ready in WAIT cycle ready_at (0 = never), samples until wb_valid.
  task automatic run_access(input int ready_at, input int max,
                            output int stl, output int req,
                            output int lat, output bit got);
    bit seen = 0;
    stl = 0; req = 0; lat = 0; got = 0;
    for (int k = 1; k <= max; k++) begin
      if (wb_valid) begin
        got = 1; lat = k - 1;
        break;
      end
      if (stall) stl++;
      if (mem_req) begin
        req++;
        if (!seen) begin
          s_addr = mem_addr; s_wdata = mem_wdata;
          s_be = mem_be; s_we = mem_we; seen = 1;
        end
      end
      mem_ready = (ready_at == k);
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++; if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_ctl stall=%b req=%b we=%b exp 0", stall, mem_req, mem_we); end
    n_tests++; if (mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus be=%h addr=%h wd=%h exp 0", mem_be, mem_addr, mem_wdata); end
    n_tests++; if (wb_valid !== 1'b0 || wb_alu_result !== 32'h0 || wb_fault !== 2'd0 || wb_pc_cur !== 32'h0) begin n_fail++; $display("FAIL reset_wb v=%b alu=%h f=%0d pc=%h exp 0", wb_valid, wb_alu_result, wb_fault, wb_pc_cur); end
  endtask

  task automatic test_alu;
    int stl, req, lat; bit got;
    push(32'h1234, 32'h0, 32'h100, 5'd5, 1'b1, 2'd0);
    issue(1'b0, 1'b0, 3'd0, 32'h1234, 32'h55, 5'd5, 1'b1, 32'h100);
    run_access(0, 8, stl, req, lat, got);
    e = sb.pop_front();
    n_tests++; if (!got || lat != 1) begin n_fail++; $display("FAIL alu_lat got=%0b lat=%0d exp 1", got, lat); end
    n_tests++; if (req != 0 || stl != 0) begin n_fail++; $display("FAIL alu_noreq req=%0d stall=%0d exp 0", req, stl); end
    n_tests++; if (wb_alu_result !== e.alu || wb_rd !== e.rd || wb_pc_cur !== e.pc) begin n_fail++; $display("FAIL alu_fields alu=%h rd=%0d pc=%h exp %h %0d %h", wb_alu_result, wb_rd, wb_pc_cur, e.alu, e.rd, e.pc); end
    n_tests++; if (wb_read_data !== e.rdata || wb_fault !== e.fault || wb_reg_write !== e.regw) begin n_fail++; $display("FAIL alu_wb rd=%h f=%0d rw=%b exp %h %0d %b", wb_read_data, wb_fault, wb_reg_write, e.rdata, e.fault, e.regw); end
    @(negedge clk);
    n_tests++; if (wb_valid !== 1'b0 || wb_alu_result !== e.alu) begin n_fail++; $display("FAIL alu_pulse v=%b alu=%h exp 0 %h", wb_valid, wb_alu_result, e.alu); end
  endtask

  task automatic test_load;
    int stl, req, lat; bit got;
    logic [2:0]  f3v[5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] av[5]  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] rv[5]  = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FF1234, 32'h80FF1234, 32'hCAFEF00D};
    logic [31:0] xv[5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'hCAFEF00D};
    for (int i = 0; i < 5; i++) begin
      mem_rdata = rv[i];
      push(av[i], xv[i], 32'h200 + i, 5'd7, 1'b1, 2'd0);
      issue(1'b1, 1'b0, f3v[i], av[i], 32'h0, 5'd7, 1'b1, 32'h200 + i);
      run_access(3, 10, stl, req, lat, got);
      e = sb.pop_front();
      n_tests++; if (!got || lat != 3 || stl != 3) begin n_fail++; $display("FAIL load%0d_timing got=%0b lat=%0d stall=%0d exp 3 3", i, got, lat, stl); end
      n_tests++; if (wb_read_data !== e.rdata || wb_fault !== e.fault || wb_reg_write !== e.regw) begin n_fail++; $display("FAIL load%0d_data rd=%h f=%0d rw=%b exp %h %0d %b", i, wb_read_data, wb_fault, wb_reg_write, e.rdata, e.fault, e.regw); end
      n_tests++; if (s_addr !== {av[i][31:2], 2'b00} || s_be !== 4'hF || s_we !== 1'b0) begin n_fail++; $display("FAIL load%0d_bus addr=%h be=%h we=%b", i, s_addr, s_be, s_we); end
      n_tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL load%0d_release req=%b stall=%b exp 0", i, mem_req, stall); end
    end
  endtask

  task automatic test_store;
    int stl, req, lat; bit got;
    logic [2:0]  f3v[3] = '{3'd1, 3'd0, 3'd2};
    logic [31:0] av[3]  = '{32'h202, 32'h201, 32'h300};
    logic [31:0] dv[3]  = '{32'hDEADBEEF, 32'h123456A5, 32'h89ABCDEF};
    logic [3:0]  bv[3]  = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wv[3]  = '{32'hBEEFBEEF, 32'hA5A5A5A5, 32'h89ABCDEF};
    for (int i = 0; i < 3; i++) begin
      push(av[i], 32'h0, 32'h300 + i, 5'd0, 1'b0, 2'd0);
      issue(1'b0, 1'b1, f3v[i], av[i], dv[i], 5'd0, 1'b0, 32'h300 + i);
      run_access(1, 8, stl, req, lat, got);
      e = sb.pop_front();
      n_tests++; if (!got || lat != 1 || stl != 1) begin n_fail++; $display("FAIL store%0d_timing got=%0b lat=%0d stall=%0d exp 1 1", i, got, lat, stl); end
      n_tests++; if (s_addr !== {av[i][31:2], 2'b00} || s_be !== bv[i] || s_wdata !== wv[i] || s_we !== 1'b1) begin n_fail++; $display("FAIL store%0d_bus addr=%h be=%b wd=%h we=%b exp be=%b wd=%h", i, s_addr, s_be, s_wdata, s_we, bv[i], wv[i]); end
      n_tests++; if (wb_read_data !== e.rdata || wb_fault !== e.fault || wb_alu_result !== e.alu) begin n_fail++; $display("FAIL store%0d_wb rd=%h f=%0d alu=%h", i, wb_read_data, wb_fault, wb_alu_result); end
    end
  endtask

  task automatic test_misaligned;
    int stl, req, lat; bit got;
    logic       rv[3]  = '{1'b1, 1'b1, 1'b1};
    logic       wv[3]  = '{1'b0, 1'b0, 1'b1};
    logic [2:0] f3v[3] = '{3'd2, 3'd3, 3'd2};
    logic [31:0] av[3] = '{32'h105, 32'h100, 32'h100};
    for (int i = 0; i < 3; i++) begin
      push(av[i], 32'h0, 32'h400 + i, 5'd9, 1'b0, 2'd1);
      issue(rv[i], wv[i], f3v[i], av[i], 32'h0, 5'd9, 1'b1, 32'h400 + i);
      run_access(1, 8, stl, req, lat, got);
      e = sb.pop_front();
      n_tests++; if (!got || lat != 1 || req != 0) begin n_fail++; $display("FAIL bad%0d_timing got=%0b lat=%0d req=%0d exp 1 0", i, got, lat, req); end
      n_tests++; if (wb_fault !== e.fault || wb_reg_write !== e.regw || wb_pc_cur !== e.pc) begin n_fail++; $display("FAIL bad%0d_wb f=%0d rw=%b pc=%h exp %0d %b %h", i, wb_fault, wb_reg_write, wb_pc_cur, e.fault, e.regw, e.pc); end
    end
  endtask

  task automatic test_timeout;
    int stl, req, lat; bit got;
    mem_rdata = 32'h11223344;
    push(32'h10, 32'h0, 32'h500, 5'd3, 1'b0, 2'd2);
    issue(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 5'd3, 1'b1, 32'h500);
    run_access(0, 10, stl, req, lat, got);
    e = sb.pop_front();
    n_tests++; if (!got || lat != 4 || req != 4) begin n_fail++; $display("FAIL tmo_timing got=%0b lat=%0d req=%0d exp 4 4", got, lat, req); end
    n_tests++; if (wb_fault !== e.fault || wb_reg_write !== e.regw || wb_read_data !== e.rdata) begin n_fail++; $display("FAIL tmo_wb f=%0d rw=%b rd=%h exp %0d %b %h", wb_fault, wb_reg_write, wb_read_data, e.fault, e.regw, e.rdata); end
    push(32'h14, 32'h11223344, 32'h504, 5'd3, 1'b1, 2'd0);
    issue(1'b1, 1'b0, 3'd2, 32'h14, 32'h0, 5'd3, 1'b1, 32'h504);
    run_access(4, 10, stl, req, lat, got);
    e = sb.pop_front();
    n_tests++; if (!got || lat != 4 || req != 4) begin n_fail++; $display("FAIL tmo_edge_timing got=%0b lat=%0d req=%0d exp 4 4", got, lat, req); end
    n_tests++; if (wb_fault !== e.fault || wb_reg_write !== e.regw || wb_read_data !== e.rdata) begin n_fail++; $display("FAIL tmo_edge_wb f=%0d rw=%b rd=%h exp %0d %b %h", wb_fault, wb_reg_write, wb_read_data, e.fault, e.regw, e.rdata); end
  endtask

  task automatic test_reset_wait;
    int stl, req, lat; bit got; bit seen_v = 0, seen_r = 0;
    issue(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 5'd4, 1'b1, 32'h600);
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL rstw_pre req=%b stall=%b exp 1 1", mem_req, stall); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_async req=%b stall=%b v=%b exp 0", mem_req, stall, wb_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wb_valid) seen_v = 1;
      if (mem_req || stall) seen_r = 1;
    end
    mem_ready = 1'b0;
    n_tests++; if (seen_v || seen_r) begin n_fail++; $display("FAIL rstw_ignore wb_valid=%0b req_or_stall=%0b exp 0 0", seen_v, seen_r); end
    push(32'hABCD, 32'h0, 32'h700, 5'd6, 1'b1, 2'd0);
    issue(1'b0, 1'b0, 3'd0, 32'hABCD, 32'h0, 5'd6, 1'b1, 32'h700);
    run_access(0, 8, stl, req, lat, got);
    e = sb.pop_front();
    n_tests++; if (!got || lat != 1 || wb_alu_result !== e.alu || wb_pc_cur !== e.pc) begin n_fail++; $display("FAIL rstw_next got=%0b lat=%0d alu=%h exp %h", got, lat, wb_alu_result, e.alu); end
  endtask

  task automatic test_back_to_back;
    bit bad_req = 0;
    mem_ready = 1'b1;
    push(32'h1111, 32'h0, 32'h800, 5'd1, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 3'd0, 32'h1111, 32'h0, 5'd1, 1'b1, 32'h800);
    @(negedge clk);
    push(32'h2222, 32'h0, 32'h804, 5'd2, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 3'd0, 32'h2222, 32'h0, 5'd2, 1'b1, 32'h804);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (mem_req || stall) bad_req = 1;
      e = sb.pop_front();
      n_tests++; if (wb_valid !== 1'b1 || wb_alu_result !== e.alu || wb_rd !== e.rd || wb_pc_cur !== e.pc) begin n_fail++; $display("FAIL b2b%0d v=%b alu=%h rd=%0d pc=%h exp 1 %h %0d %h", i, wb_valid, wb_alu_result, wb_rd, wb_pc_cur, e.alu, e.rd, e.pc); end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    n_tests++; if (wb_valid !== 1'b0 || bad_req) begin n_fail++; $display("FAIL b2b_end v=%b req_seen=%0b exp 0 0", wb_valid, bad_req); end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_left size=%0d exp 0", sb.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_alu_result = '0; in_rd2 = '0; in_funct3 = '0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0;
    in_result_src = '0; in_rd = '0; in_pc_cur = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_alu;
    test_load;
    test_store;
    test_misaligned;
    test_timeout;
    test_reset_wait;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT cycles before a bus error is declared; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low.
REQ-004 in_valid  input  1  EX-to-MEM bundle holds a valid instruction.
REQ-005 in_alu_result  input  32  effective address, or ALU result for non-memory instructions.
REQ-006 in_rd2  input  32  store data.
REQ-007 in_funct3  input  3  access size and sign (RV32I load/store encoding).
REQ-008 in_mem_read / in_mem_write  input  1 each  load or store; both high is illegal and is treated as a fault.
REQ-009 in_reg_write  input  1;  in_result_src  input  2;  in_rd  input  5;  in_pc_cur  input  32  writeback controls, passed through.
REQ-010 stall  output  1  upstream holds its bundle while high.
REQ-011 mem_req  output  1;  mem_we  output  1;  mem_addr  output  32 (bits [1:0] forced to 0);  mem_wdata  output  32;  mem_be  output  4  data-memory request.
REQ-012 mem_ready  input  1;  mem_rdata  input  32  memory completion and word read data.
REQ-013 wb_valid  output  1;  wb_reg_write  output  1;  wb_result_src  output  2;  wb_rd  output  5;  wb_alu_result  output  32;  wb_read_data  output  32;  wb_pc_cur  output  32;  wb_fault  output  2 (0 none, 1 misaligned/illegal, 2 bus timeout)  registered MEM-to-WB bundle.

Function
REQ-014 FSM states: IDLE, WAIT; stall SHALL equal (state == WAIT).
REQ-015 The block SHALL accept in_valid only in IDLE, capturing all inputs into internal registers on that edge.
REQ-016 Non-memory instruction accepted at edge T: wb_valid high for exactly one cycle after edge T+1 (latency 1), fields copied, wb_read_data = 0, wb_fault = 0; state stays IDLE.
REQ-017 Legal aligned load/store accepted at edge T: state goes to WAIT; mem_req asserted from edge T and held with constant addr/we/wdata/be until the cycle mem_ready is sampled high.
REQ-018 WAIT with mem_ready high: deassert mem_req, register the wb bundle, return to IDLE; wb_valid high for one cycle; minimum load/store latency 2 edges.
REQ-019 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; load funct3 3/6/7, store funct3 >=3, or read and write both high: illegal.
REQ-020 Misaligned/illegal: no bus request; wb bundle registered at latency 1 with wb_fault=1 and wb_reg_write forced 0.
REQ-021 Byte enables: SB 4'b0001<<addr[1:0], wdata = 4 copies of rd2[7:0]; SH 4'b0011<<(2*addr[1]), wdata = 2 copies of rd2[15:0]; SW 4'b1111, wdata = rd2; loads drive mem_be = 4'b1111, mem_we = 0.
REQ-022 Load extraction from mem_rdata by addr[1:0]: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
REQ-023 A WAIT cycle counter SHALL clear on WAIT entry and increment each WAIT cycle without mem_ready; on reaching TIMEOUT_CYCLES: drop mem_req, return to IDLE, emit the bundle with wb_fault=2, wb_reg_write 0, wb_read_data 0.
REQ-024 mem_ready high in the same cycle the counter reaches TIMEOUT_CYCLES: completion wins, with no fault.
REQ-025 mem_ready while IDLE or while mem_req is low SHALL be ignored.
REQ-026 wb_valid SHALL be low in every cycle not defined above; other wb fields hold their last value.

Reset
REQ-027 reset low SHALL immediately, asynchronously, force: state IDLE, stall 0, mem_req 0, mem_we 0, mem_be 0, mem_addr/mem_wdata 0, counter 0, all wb outputs 0.
REQ-028 Reset during WAIT SHALL abandon the access with no wb_valid; a later mem_ready SHALL be ignored.

Verification
REQ-029 ADD-type bundle, alu_result 0x1234 -> next cycle wb_valid=1, wb_alu_result=0x1234, mem_req never high.
REQ-030 LB at addr 0x103, mem_rdata 0x80FF_FF_FF, ready after 3 WAIT cycles -> stall high 3 cycles, wb_read_data 0xFFFFFF80; as LBU -> 0x00000080.
REQ-031 SH at addr 0x202, rd2 0xDEADBEEF, ready first cycle -> mem_addr 0x200, mem_be 4'b1100, mem_wdata 0xBEEFBEEF, mem_we 1.
REQ-032 LW at addr 0x105 -> no mem_req, wb_fault 1, wb_reg_write 0, latency 1.
REQ-033 TIMEOUT_CYCLES 4, mem_ready never high -> mem_req high 4 cycles, then wb_fault 2; ready on the 4th cycle -> no fault.
REQ-034 reset asserted in the second WAIT cycle -> mem_req and stall drop asynchronously, no wb_valid, next bundle accepted normally.
